// File: rtl/mmcm_reconfig_ctrl_if.sv
// Mode-request handshake between a video-mode requester and the MMCM reconfiguration controller.
interface mmcm_reconfig_ctrl_if #(
    parameter int unsigned MODE_W = 2
);
    logic [MODE_W-1:0] mode_sel;
    logic              mode_valid;
    logic              mode_ready;
    logic              busy;
    logic              done;
    logic              error;
    logic [MODE_W-1:0] current_mode;

    modport master (
        output mode_sel, mode_valid,
        input  mode_ready, busy, done, error, current_mode
    );

    modport slave (
        input  mode_sel, mode_valid,
        output mode_ready, busy, done, error, current_mode
    );
endinterface

// File: rtl/mmcm_reconfig_ctrl.sv
// Runtime pixel-clock MMCM reconfiguration: holds the MMCM in reset, read-modify-writes
// its DRP registers from a per-mode ROM, releases reset and waits for lock.
module mmcm_reconfig_ctrl #(
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned WRITES_PER_MODE = 10,
    parameter int unsigned DRDY_TIMEOUT    = 255,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned ROM_AW          = $clog2(NUM_MODES * WRITES_PER_MODE)
) (
    input  logic              clk_33,
    input  logic              rst_n,
    mmcm_reconfig_ctrl_if.slave mode_if,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [38:0]       rom_data,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [6:0]        drp_daddr,
    output logic [15:0]       drp_di,
    input  logic [15:0]       drp_do,
    input  logic              drp_drdy,
    output logic              mmcm_rst,
    input  logic              mmcm_locked
);
    localparam int unsigned MODE_W = $clog2(NUM_MODES);
    localparam int unsigned IDX_W  = $clog2(WRITES_PER_MODE);
    localparam int unsigned CNT_W  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_ASSERT, S_FETCH, S_RD, S_RD_WAIT, S_WR,
        S_WR_WAIT, S_NEXT, S_RST_RELEASE, S_LOCK_WAIT, S_DONE, S_ERROR
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                fetch_ph_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   cur_mode_q;
    logic [15:0]         mask_q;
    logic [15:0]         data_q;
    logic                lock_meta_q;
    logic                lock_sync_q;
    logic                mode_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic                drp_den_q;
    logic                drp_dwe_q;
    logic [6:0]          drp_daddr_q;
    logic [15:0]         drp_di_q;
    logic                mmcm_rst_q;
    logic [15:0]         rmw_c;

    // Mask bit 1 keeps the current register bit; data is assumed zero under the mask.
    assign rmw_c = (drp_do & mask_q) | data_q;

    always_ff @(posedge clk_33) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            fetch_ph_q   <= 1'b0;
            cnt_q        <= '0;
            mode_q       <= '0;
            cur_mode_q   <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            mode_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rom_addr_q   <= '0;
            drp_den_q    <= 1'b0;
            drp_dwe_q    <= 1'b0;
            drp_daddr_q  <= '0;
            drp_di_q     <= '0;
            mmcm_rst_q   <= 1'b0;
        end else begin
            lock_meta_q <= mmcm_locked;
            lock_sync_q <= lock_meta_q;
            done_q      <= 1'b0;
            drp_den_q   <= 1'b0;
            drp_dwe_q   <= 1'b0;
            cnt_q       <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (mode_if.mode_valid && mode_ready_q) begin
                        mode_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        mode_q       <= mode_if.mode_sel;
                        if (mode_if.mode_sel == cur_mode_q && !error_q) begin
                            state_q <= S_DONE;
                        end else begin
                            error_q <= 1'b0;
                            state_q <= S_RST_ASSERT;
                        end
                    end
                end
                S_RST_ASSERT: begin
                    mmcm_rst_q <= 1'b1;
                    idx_q      <= '0;
                    fetch_ph_q <= 1'b0;
                    rom_addr_q <= ROM_AW'(32'(mode_q) * WRITES_PER_MODE);
                    state_q    <= S_FETCH;
                end
                // Address is already on the ROM; second cycle captures the registered word.
                S_FETCH: begin
                    if (!fetch_ph_q) begin
                        fetch_ph_q <= 1'b1;
                    end else begin
                        fetch_ph_q  <= 1'b0;
                        drp_daddr_q <= rom_data[38:32];
                        mask_q      <= rom_data[31:16];
                        data_q      <= rom_data[15:0];
                        drp_den_q   <= 1'b1;
                        state_q     <= S_RD;
                    end
                end
                S_RD: state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (drp_drdy) begin
                        drp_di_q  <= rmw_c;
                        drp_den_q <= 1'b1;
                        drp_dwe_q <= 1'b1;
                        state_q   <= S_WR;
                    end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR: state_q <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (drp_drdy) begin
                        state_q <= S_NEXT;
                    end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (idx_q == IDX_W'(WRITES_PER_MODE - 1)) begin
                        state_q <= S_RST_RELEASE;
                    end else begin
                        idx_q      <= idx_q + IDX_W'(1);
                        rom_addr_q <= rom_addr_q + ROM_AW'(1);
                        state_q    <= S_FETCH;
                    end
                end
                S_RST_RELEASE: begin
                    mmcm_rst_q <= 1'b0;
                    state_q    <= S_LOCK_WAIT;
                end
                S_LOCK_WAIT: begin
                    if (lock_sync_q) begin
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q       <= 1'b1;
                    cur_mode_q   <= mode_q;
                    busy_q       <= 1'b0;
                    mode_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_ERROR: begin
                    error_q      <= 1'b1;
                    mmcm_rst_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    mode_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mode_if.mode_ready   = mode_ready_q;
    assign mode_if.busy         = busy_q;
    assign mode_if.done         = done_q;
    assign mode_if.error        = error_q;
    assign mode_if.current_mode = cur_mode_q;
    assign rom_addr             = rom_addr_q;
    assign drp_den              = drp_den_q;
    assign drp_dwe              = drp_dwe_q;
    assign drp_daddr            = drp_daddr_q;
    assign drp_di               = drp_di_q;
    assign mmcm_rst             = mmcm_rst_q;
endmodule

// File: doc/mmcm_reconfig_ctrl.md
# mmcm_reconfig_ctrl

Runtime video-mode switcher for the pixel-clock MMCM. On a mode request it holds the MMCM in reset, rewrites its divider/filter/lock registers through the DRP port from an external per-mode configuration ROM, releases reset and waits for lock. It replaces compile-time pixel-clock selection with a handshake-driven reconfiguration sequence in the `clk_33` domain.

## Interface
- `NUM_MODES`, 4: number of video modes; mode index 0..3 corresponds to video ID code 1..4.
- `WRITES_PER_MODE`, 10: DRP register writes per mode.
- `DRDY_TIMEOUT`, 255: maximum cycles to wait for `drp_drdy` per access.
- `LOCK_TIMEOUT`, 65535: maximum cycles to wait for lock after releasing reset.
- `ROM_AW`, `$clog2(NUM_MODES*WRITES_PER_MODE)`: ROM address width.
- `clk_33`, input, 1: the only clock; it also drives the DRP clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `mode_sel`, input, 2: requested mode index.
- `mode_valid`, input, 1: request strobe.
- `mode_ready`, output, 1: high only in IDLE; a request is accepted when `mode_valid && mode_ready`.
- `busy`, output, 1: high from acceptance until DONE or ERROR.
- `done`, output, 1: one-cycle pulse on successful completion.
- `error`, output, 1: sticky; cleared by the next accepted request.
- `current_mode`, output, 2: last successfully configured mode.
- `rom_addr`, output, ROM_AW: ROM address.
- `rom_data`, input, 39: ROM word {daddr[38:32], mask[31:16], data[15:0]}; registered ROM with 1-cycle read latency.
- `drp_den`, `drp_dwe`, output, 1 each: DRP enable and write enable.
- `drp_daddr`, output, 7: DRP address.
- `drp_di`, output, 16: DRP write data.
- `drp_do`, input, 16: DRP read data.
- `drp_drdy`, input, 1: DRP ready.
- `mmcm_rst`, output, 1: MMCM reset.
- `mmcm_locked`, input, 1: asynchronous lock flag; synchronized internally with 2 flops.

## Operation
- Reset values: `mode_ready`=1, `busy`=0, `done`=0, `error`=0, `current_mode`=0, `rom_addr`=0, `drp_den`=0, `drp_dwe`=0, `drp_daddr`=0, `drp_di`=0, `mmcm_rst`=0. The FSM resets to IDLE and the write index to 0.
- State machine states: IDLE, RST_ASSERT, FETCH, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_RELEASE, LOCK_WAIT, DONE, ERROR.
- IDLE, request accepted with `mode_sel == current_mode` and `error` == 0: go to DONE. No DRP traffic and no MMCM reset occur.
- IDLE, any other accepted request: latch `mode_sel`, clear `error`, go to RST_ASSERT.
- RST_ASSERT: set `mmcm_rst`=1; index=0; go to FETCH.
- FETCH: `rom_addr` = mode*WRITES_PER_MODE + index; wait 1 cycle, then register `rom_data`; go to RD.
- RD: one-cycle `drp_den`=1, `drp_dwe`=0, `drp_daddr` = daddr; go to RD_WAIT.
- RD_WAIT: on `drp_drdy`, compute `drp_di` = (`drp_do` & mask) | data; go to WR. Mask bit 1 keeps the existing bit. The data field must be 0 wherever mask is 1; `data` is not masked internally.
- WR: one-cycle `drp_den`=1, `drp_dwe`=1 with `drp_daddr`/`drp_di` held; go to WR_WAIT.
- WR_WAIT: on `drp_drdy`, go to NEXT.
- NEXT: if index == WRITES_PER_MODE-1, go to RST_RELEASE; else index+1 and go to FETCH.
- RST_RELEASE: `mmcm_rst`=0; go to LOCK_WAIT.
- LOCK_WAIT: on synchronized lock == 1, go to DONE.
- DONE: pulse `done`; update `current_mode` to the latched mode; return to IDLE.
- ERROR: set `error`=1; drive `mmcm_rst`=0; leave `current_mode` unchanged; return to IDLE.
- Timeouts:
  - A per-state counter runs in RD_WAIT, WR_WAIT and LOCK_WAIT.
  - Reaching DRDY_TIMEOUT or LOCK_TIMEOUT cycles without the awaited event goes to ERROR.
  - The counter clears on every state entry.

## Timing
- `drp_den` is high for exactly one cycle per access and is never reasserted before `drp_drdy` for the previous access.
- `drp_drdy` arriving in the same cycle as `drp_den` is ignored; only RD_WAIT and WR_WAIT sample it.
- Cycles per register = 1 (FETCH addr) + 1 (ROM latency) + 1 (RD) + r + 1 (WR) + w + 1 (NEXT), where r and w are the DRP response latencies, each ≥ 1.
- `mmcm_rst` is high from the cycle after RST_ASSERT until RST_RELEASE, and is high during every DRP write.
- Lock detection adds 2 cycles of synchronizer latency.
- `mode_valid` while `busy`: not accepted, not queued (`mode_ready`=0).
- `rst_n` low in any state: all outputs return to reset values on the next edge.
- A reset mid-sequence leaves the MMCM contents undefined; recovery requires a new request to a mode different from 0, or any request while `error`=1.
- Lock dropping after DONE is not monitored.

## Test plan
- Mode 0→2 request with a DRP model at r=w=3 and lock 100 cycles after reset release → 10 read/write pairs at ROM addresses 20..29. Required: `mmcm_rst` high throughout the writes, one `done` pulse, `current_mode`=2, `error`=0.
- RMW check: `drp_do`=0xFFFF, mask=0x00F0, data=0x1203 → `drp_di`=0x12F3.
- Request for the current mode (mode 0 after reset) → `done` 2 cycles after acceptance, with no `drp_den` and no `mmcm_rst` activity.
- DRP model never asserts `drp_drdy` → ERROR after 255 wait cycles. Required: `error`=1, `mmcm_rst`=0, `current_mode` unchanged. The next request clears `error`.
- `mmcm_locked` held low → ERROR after 65535 cycles in LOCK_WAIT. A second `mode_valid` pulse issued while `busy` is ignored.
- `rst_n` low during WR_WAIT → next cycle all outputs are at reset values and `mode_ready`=1. A following request to mode 3 completes normally.
